// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Registered execute stage fed by the ALU control decoder. A request is
// taken with iStart whenever the unit is not busy (IDLE or DONE). Logic,
// arithmetic, compare and branch-condition ops finish at the accept edge.
// Shifts either iterate one bit per cycle (default build) or use a
// combinational barrel shifter when ALU_FAST_SHIFT_EN is defined.
//
// Configuration macro:
//   ALU_FAST_SHIFT_EN - single-cycle barrel shifter, no SHIFT state,
//                       oBusy tied low.
//
// Ports:
//   iCLK            clock, rising edge
//   iRST            asynchronous active-high reset
//   iStart          request, sampled only in IDLE/DONE
//   iControlSignal  5-bit ALU operation code
//   iA, iB          operands (shift amount is iB[4:0])
//   oBusy           high during iterative shift cycles
//   oDone           one-cycle completion pulse
//   oResult         registered result, held until the next completion
//   oZero           registered (oResult == 0)
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [4:0]       iControlSignal,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult,
  output logic             oZero
);

  // Shared ALU operation encodings
  localparam logic [4:0] OPADD  = 5'd0;
  localparam logic [4:0] OPSUB  = 5'd1;
  localparam logic [4:0] OPAND  = 5'd2;
  localparam logic [4:0] OPOR   = 5'd3;
  localparam logic [4:0] OPXOR  = 5'd4;
  localparam logic [4:0] OPSLT  = 5'd5;
  localparam logic [4:0] OPSLTU = 5'd6;
  localparam logic [4:0] OPSLL  = 5'd7;
  localparam logic [4:0] OPSRL  = 5'd8;
  localparam logic [4:0] OPSRA  = 5'd9;
  localparam logic [4:0] OPLUI  = 5'd10;
  localparam logic [4:0] OPBEQ  = 5'd11;
  localparam logic [4:0] OPBNE  = 5'd12;
  localparam logic [4:0] OPGE   = 5'd13;
  localparam logic [4:0] OPGEU  = 5'd14;

`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [WIDTH-1:0] w_opResult;
  logic             w_accept;

  assign w_accept = iStart && (r_state != state_t'(IDLE) ? (r_state == DONE) : 1'b1);

  // Single-cycle result for everything that completes at the accept edge.
  // In the fast build the shifts are part of this path as well.
  always_comb begin
    w_opResult = '0;
    case (iControlSignal)
      OPADD:  w_opResult = iA + iB;
      OPSUB:  w_opResult = iA - iB;
      OPAND:  w_opResult = iA & iB;
      OPOR:   w_opResult = iA | iB;
      OPXOR:  w_opResult = iA ^ iB;
      OPSLT:  w_opResult = {{(WIDTH-1){1'b0}}, ($signed(iA) < $signed(iB))};
      OPSLTU: w_opResult = {{(WIDTH-1){1'b0}}, (iA < iB)};
      OPLUI:  w_opResult = iB;
      OPBEQ:  w_opResult = {{(WIDTH-1){1'b0}}, (iA == iB)};
      OPBNE:  w_opResult = {{(WIDTH-1){1'b0}}, (iA != iB)};
      OPGE:   w_opResult = {{(WIDTH-1){1'b0}}, ($signed(iA) >= $signed(iB))};
      OPGEU:  w_opResult = {{(WIDTH-1){1'b0}}, (iA >= iB)};
`ifdef ALU_FAST_SHIFT_EN
      OPSLL:  w_opResult = iA << iB[4:0];
      OPSRL:  w_opResult = iA >> iB[4:0];
      OPSRA:  w_opResult = $signed(iA) >>> iB[4:0];
`endif
      default: w_opResult = '0;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN

  // Every op, shifts included, finishes at the accept edge; DONE falls
  // back to IDLE unless a chained request is accepted.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else if (w_accept) begin
      r_result <= w_opResult;
      r_zero   <= (w_opResult == '0);
      r_state  <= DONE;
    end else begin
      r_state  <= IDLE;
    end
  end

  assign oBusy = 1'b0;

`else

  logic [WIDTH-1:0] r_shiftReg;
  logic [4:0]       r_cnt;
  logic [4:0]       r_op;
  logic [WIDTH-1:0] w_shiftNext;
  logic             w_isShift;

  assign w_isShift = (iControlSignal == OPSLL) || (iControlSignal == OPSRL) ||
                     (iControlSignal == OPSRA);

  // One-bit step of the iterative shifter, direction/fill chosen by the
  // op latched at accept so operand or code changes mid-shift are ignored.
  always_comb begin
    w_shiftNext = r_shiftReg;
    case (r_op)
      OPSLL:   w_shiftNext = {r_shiftReg[WIDTH-2:0], 1'b0};
      OPSRL:   w_shiftNext = {1'b0, r_shiftReg[WIDTH-1:1]};
      OPSRA:   w_shiftNext = {r_shiftReg[WIDTH-1], r_shiftReg[WIDTH-1:1]};
      default: w_shiftNext = r_shiftReg;
    endcase
  end

  // Control FSM. A zero-length shift completes like a one-cycle op with
  // the untouched operand A; otherwise the last SHIFT edge (cnt==1) writes
  // the final shifted value straight into the result register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state    <= IDLE;
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_shiftReg <= '0;
      r_cnt      <= '0;
      r_op       <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (iStart) begin
            if (w_isShift) begin
              r_shiftReg <= iA;
              r_cnt      <= iB[4:0];
              r_op       <= iControlSignal;
              if (iB[4:0] == 5'd0) begin
                r_result <= iA;
                r_zero   <= (iA == '0);
                r_state  <= DONE;
              end else begin
                r_state  <= SHIFT;
              end
            end else begin
              r_result <= w_opResult;
              r_zero   <= (w_opResult == '0);
              r_state  <= DONE;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_shiftReg <= w_shiftNext;
          r_cnt      <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_result <= w_shiftNext;
            r_zero   <= (w_shiftNext == '0);
            r_state  <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oBusy = (r_state == SHIFT);

`endif

  assign oDone   = (r_state == DONE);
  assign oResult = r_result;
  assign oZero   = r_zero;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execute stage sitting directly downstream of the ALU control decoder. It accepts the 5-bit ALU operation code plus two 32-bit operands under a start/done handshake. Logic, arithmetic, compare and branch-condition ops complete in one cycle; shifts run iteratively, one bit per cycle. The multicycle core controller holds the instruction in its EX state until `oDone`.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; shift amount is `iB[4:0]`.

Ports:
- `iCLK`  in  1  clock; all state updates on the rising edge.
- `iRST`  in  1  reset, asynchronous, active-high.
- `iStart`  in  1  request; sampled only when the unit is not busy.
- `iControlSignal`  in  5  operation code from the ALU control decoder: `OPADD`, `OPSUB`, `OPAND`, `OPOR`, `OPXOR`, `OPSLT`, `OPSLTU`, `OPSLL`, `OPSRL`, `OPSRA`, `OPLUI`, `OPBEQ`, `OPBNE`, `OPGE`, `OPGEU`; encodings come from the shared ALU operation definitions.
- `iA`  in  WIDTH  operand A (rs1).
- `iB`  in  WIDTH  operand B (rs2 or immediate).
- `oBusy`  out  1  high while a shift is iterating.
- `oDone`  out  1  one-cycle pulse; `oResult`/`oZero` valid this cycle.
- `oResult`  out  WIDTH  registered result; holds until the next accepted start.
- `oZero`  out  1  registered `(oResult == 0)`.

## Operation
- States: IDLE, SHIFT, DONE.
- Start is accepted when `iStart=1` and the state is IDLE or DONE. Back-to-back requests are allowed in the DONE cycle.
- Non-shift op accepted: result is computed and registered at the accept edge; next state is DONE.
  - ADD/SUB: modulo 2^32, no carry or overflow output.
  - SLT/SLTU: signed/unsigned A<B, giving 1 or 0.
  - LUI: result = B.
  - BEQ/BNE/GE/GEU: result = 1 if the condition is true, else 0.
- Unknown code: result 0, treated as non-shift.
- Shift op accepted: the shift register loads A, `cnt` loads `iB[4:0]`, and the op is latched.
  - If `cnt=0`: next state is DONE, result = A.
  - Otherwise: next state is SHIFT.
- SHIFT: each cycle shift by 1 and decrement `cnt`.
  - SLL: fill 0 from the LSB.
  - SRL: fill 0 from the MSB.
  - SRA: replicate the MSB.
  - At `cnt==1`, the edge writes the final shift to `oResult` and moves to DONE.
- `iStart` during SHIFT is ignored (not queued). Operand changes during SHIFT have no effect.
- DONE: `oDone=1`. Next state is IDLE unless a new start is accepted.
- Reset, asynchronous and mid-operation included: state IDLE, `oResult=0`, `oZero=1`, `oDone=0`, `oBusy=0`, `cnt=0`. An in-flight shift is discarded.

## Timing
- Latency is counted from the accept edge (cycle 0) to the `oDone` cycle.
  - Non-shift op: 1 cycle.
  - Shift by n: n+1 cycles for n≥1; 1 cycle for n=0.
- `oBusy=1` exactly during the n SHIFT cycles. `oBusy` and `oDone` are never high together.
- `oResult`/`oZero` change only on the accept edge (non-shift or n=0) or the final SHIFT edge. They are stable from `oDone` until the next completion.
- Maximum shift occupancy: 31 SHIFT cycles.
- Throughput is one non-shift op per cycle via DONE→accept chaining.

## Configuration
- `ALU_FAST_SHIFT_EN` defined:
  - Shifts use a combinational barrel shifter and complete in 1 cycle like other ops.
  - SHIFT state and `cnt` are not built; `oBusy` is tied 0.
- Undefined: iterative shifter as described above, one bit per cycle.
- Results are bit-identical in both builds; only latency differs.

## Test plan
- Reset asserted mid-SHIFT (SLL, A=1, B=20, reset at cycle 5) -> outputs return to reset values asynchronously; no `oDone` pulse follows release.
- ADD A=0xFFFFFFFF, B=1 -> `oDone` at cycle 1, `oResult=0`, `oZero=1`. Then SUB A=5, B=7 accepted in the DONE cycle -> `oResult=0xFFFFFFFE` next cycle.
- SRA A=0x80000000, B=31 -> `oBusy` high for 31 cycles, `oDone` at cycle 32, `oResult=0xFFFFFFFF`. A second `iStart` at cycle 10 is ignored.
- SLL A=0x12345678, B=0 -> `oDone` at cycle 1, `oResult=0x12345678`, `oBusy` never high.
- SLT A=0xFFFFFFFF, B=1 -> `oResult=1`; SLTU with the same operands -> `oResult=0`; BGEU A=3, B=3 -> `oResult=1`.
- With `ALU_FAST_SHIFT_EN`: SRL A=0xF0000000, B=4 -> `oDone` at cycle 1, `oResult=0x0F000000`.
